seq_alu: RTL and testbench

- Clocked, parametrised successor to the team's combinational 8-function logical/arithmetic unit.
- Same 3-bit function set: sub, add, mul, div, logical AND, bitwise AND, reduction AND, concat.
- Operands are registered behind a valid/ready handshake. The result is held until consumed.
- Division is a multi-cycle restoring divider with divide-by-zero detection. Used wherever a shared, back-pressurable arithmetic/logic resource is needed.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 168 ++++++++++++++++
 tb/tb_seq_alu.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: operand/opcode request channel and held-result response channel.
interface seq_alu_if #(
  parameter int WIDTH = 4
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2:0]             op;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     y;
  logic                   zero;
  logic                   err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, err
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential 8-function ALU: single-cycle ops finish in one cycle, unsigned division
// runs a restoring divider for WIDTH cycles; the result is held until consumed.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int         CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_DIV = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_y;
  logic                 r_zero;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_div_start;
  logic                 w_div_zero;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_result;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;

  assign w_accept    = bus.in_valid && (r_state == IDLE);
  assign w_div_zero  = (bus.op == OP_DIV) && (bus.b == {WIDTH{1'b0}});
  assign w_div_start = w_accept && (bus.op == OP_DIV) && !w_div_zero;
  assign w_a_ext     = {{WIDTH{1'b0}}, bus.a};
  assign w_b_ext     = {{WIDTH{1'b0}}, bus.b};

  // Single-cycle function table; op3 here only covers the divide-by-zero case.
  always_comb begin
    w_result = {(2*WIDTH){1'b0}};
    case (bus.op)
      3'd0:    w_result = w_a_ext - w_b_ext;
      3'd1:    w_result = w_a_ext + w_b_ext;
      3'd2:    w_result = w_a_ext * w_b_ext;
      3'd3:    w_result = {bus.a, {WIDTH{1'b1}}};
      3'd4:    w_result = {{(2*WIDTH-1){1'b0}}, ((|bus.a) && (|bus.b))};
      3'd5:    w_result = {{WIDTH{1'b0}}, bus.a & bus.b};
      3'd6:    w_result = {{(2*WIDTH-1){1'b0}}, &bus.a};
      3'd7:    w_result = {bus.a, bus.b};
      default: w_result = {(2*WIDTH){1'b0}};
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    w_trial = {r_rem, r_a[r_cnt]};
    w_diff  = w_trial - {1'b0, r_b};
    w_qbit  = (w_trial >= {1'b0, r_b});
    if (w_qbit) begin
      w_rem_next = w_diff[WIDTH-1:0];
    end else begin
      w_rem_next = w_trial[WIDTH-1:0];
    end
    w_quo_next = {r_quo[WIDTH-2:0], w_qbit};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_div_start) begin
            w_state_next = DIV;
          end else begin
            w_state_next = DONE;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      DIV: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_next = DONE;
        end else begin
          w_state_next = DIV;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, divider iteration and result registers; DONE holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_rem  <= {WIDTH{1'b0}};
      r_quo  <= {WIDTH{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_y    <= {(2*WIDTH){1'b0}};
      r_zero <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a <= bus.a;
            r_b <= bus.b;
            if (w_div_start) begin
              r_rem <= {WIDTH{1'b0}};
              r_quo <= {WIDTH{1'b0}};
              r_cnt <= CNT_W'(WIDTH - 1);
            end else begin
              r_y    <= w_result;
              r_zero <= (w_result == {(2*WIDTH){1'b0}});
              r_err  <= w_div_zero;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_y    <= {w_rem_next, w_quo_next};
            r_zero <= ({w_rem_next, w_quo_next} == {(2*WIDTH){1'b0}});
            r_err  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.y         = r_y;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=4.
module tb_seq_alu;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  seq_alu_if #(.WIDTH(4)) bus ();

  seq_alu #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one operation for a single accept edge, then scramble the inputs.
  task automatic issue(input logic [2:0] o, input logic [3:0] aa, input logic [3:0] bb);
    bus.op       = o;
    bus.a        = aa;
    bus.b        = bb;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op       = ~o;
    bus.a        = ~aa;
    bus.b        = ~bb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = 4'h0;
    bus.b = 4'h0;
    bus.op = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.y !== 8'h00) $display("FAIL reset_y: got %h want 00", bus.y); else n_pass++;
    n_total++; if (bus.zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", bus.zero); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else n_pass++;
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_y [8] = '{8'h07, 8'h0D, 8'h1E, 8'h13, 8'h01, 8'h02, 8'h00, 8'hA3};
    int cyc;
    for (int o = 0; o < 8; o++) begin
      issue(3'(o), 4'hA, 4'h3);
      cyc = 1;
      if (o == 3) begin
        while (!bus.out_valid && cyc < 20) begin
          tick();
          cyc++;
        end
      end
      n_total++; if (bus.out_valid !== 1'b1) $display("FAIL sweep_valid op%0d: got %b want 1", o, bus.out_valid); else n_pass++;
      n_total++; if (cyc !== ((o == 3) ? 5 : 1)) $display("FAIL sweep_latency op%0d: got %0d want %0d", o, cyc, (o == 3) ? 5 : 1); else n_pass++;
      n_total++; if (bus.y !== exp_y[o]) $display("FAIL sweep_y op%0d: got %h want %h", o, bus.y, exp_y[o]); else n_pass++;
      n_total++; if (bus.zero !== (o == 6)) $display("FAIL sweep_zero op%0d: got %b want %b", o, bus.zero, (o == 6)); else n_pass++;
      n_total++; if (bus.err !== 1'b0) $display("FAIL sweep_err op%0d: got %b want 0", o, bus.err); else n_pass++;
      tick();
    end
  endtask

  task automatic test_wrap();
    issue(3'd0, 4'h3, 4'h5);
    n_total++; if (bus.y !== 8'hFE) $display("FAIL wrap_sub_y: got %h want fe", bus.y); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL wrap_sub_err: got %b want 0", bus.err); else n_pass++;
    tick();
    issue(3'd1, 4'hF, 4'hF);
    n_total++; if (bus.y !== 8'h1E) $display("FAIL wide_add_y: got %h want 1e", bus.y); else n_pass++;
    tick();
  endtask

  task automatic test_div_zero();
    issue(3'd3, 4'h9, 4'h0);
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL divz_latency: got out_valid %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.y !== 8'h9F) $display("FAIL divz_y: got %h want 9f", bus.y); else n_pass++;
    n_total++; if (bus.err !== 1'b1) $display("FAIL divz_err: got %b want 1", bus.err); else n_pass++;
    n_total++; if (bus.zero !== 1'b0) $display("FAIL divz_zero: got %b want 0", bus.zero); else n_pass++;
    tick();
    issue(3'd1, 4'h1, 4'h1);
    n_total++; if (bus.err !== 1'b0) $display("FAIL divz_next_err: got %b want 0", bus.err); else n_pass++;
    n_total++; if (bus.y !== 8'h02) $display("FAIL divz_next_y: got %h want 02", bus.y); else n_pass++;
    tick();
  endtask

  task automatic test_div();
    int cyc;
    int n_busy;
    issue(3'd3, 4'hF, 4'h2);
    cyc = 1;
    n_busy = 0;
    while (!bus.out_valid && cyc < 20) begin
      if (!bus.in_ready) n_busy++;
      bus.in_valid = 1'b1;
      bus.op = 3'd1;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_total++; if (n_busy !== 4) $display("FAIL div_busy_cycles: got %0d want 4", n_busy); else n_pass++;
    n_total++; if (cyc !== 5) $display("FAIL div_latency: got %0d want 5", cyc); else n_pass++;
    n_total++; if (bus.y !== 8'h17) $display("FAIL div_y: got %h want 17", bus.y); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL div_err: got %b want 0", bus.err); else n_pass++;
    tick();
    n_total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL div_idle_after: got ready %b valid %b want 1 0", bus.in_ready, bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    issue(3'd2, 4'h7, 4'h7);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op = 3'd1;
      bus.a = 4'h1;
      bus.b = 4'h1;
      n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid c%0d: got %b want 1", i, bus.out_valid); else n_pass++;
      n_total++; if (bus.y !== 8'h31) $display("FAIL bp_y c%0d: got %h want 31", i, bus.y); else n_pass++;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b want 0", i, bus.in_ready); else n_pass++;
      if (i < 4) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.y !== 8'h31) $display("FAIL bp_retain_y: got %h want 31", bus.y); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h02) $display("FAIL bp_next_op: got valid %b y %h want 1 02", bus.out_valid, bus.y); else n_pass++;
    tick();
  endtask

  task automatic test_reset_during_div();
    int seen;
    issue(3'd3, 4'hD, 4'h4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rdiv_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.y !== 8'h00) $display("FAIL rdiv_y: got %h want 00", bus.y); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rdiv_ready: got %b want 1", bus.in_ready); else n_pass++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    n_total++; if (seen !== 0) $display("FAIL rdiv_ghost_result: got %0d valid cycles want 0", seen); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_op_sweep();
    test_wrap();
    test_div_zero();
    test_div();
    test_back_pressure();
    test_reset_during_div();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
